// File: rtl/jstk_spi_ctrl.sv
// jstk_spi_ctrl: SPI mode-0 master that runs one 5-byte PmodJSTK2 exchange per SNDREC rising edge.
// Optional macro JSTK_SNDREC_SYNC_EN adds a 2-flop synchronizer on SNDREC (+2 cycles latency).
`default_nettype none
`timescale 1ns/1ps

module jstk_spi_ctrl #(
  parameter int SCLK_HALF = 6,
  parameter int SS_SETUP  = 180,
  parameter int BYTE_GAP  = 180
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNDREC,
  input  logic [7:0]  DIN,
  input  logic        MISO,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  output logic        BUSY,
  output logic [39:0] DOUT,
  output logic        DVALID
);

  localparam int MAX_A   = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int MAX_CNT = (MAX_A > SCLK_HALF) ? MAX_A : SCLK_HALF;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state, next_state;
  logic [CW-1:0] cnt;
  logic          phase;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_cnt;
  logic [7:0]    cmd;
  logic [39:0]   rx_shift;
  logic [39:0]   dout_r;
  logic          mosi_r;
  logic          sndrec_cur, sndrec_prev;
  logic          sndrec_in;

  logic start, setup_end, half_end, gap_end, bit_end, byte_end, last_byte;

`ifdef JSTK_SNDREC_SYNC_EN
  logic sync_ff1, sync_ff2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= SNDREC;
      sync_ff2 <= sync_ff1;
    end
  end

  assign sndrec_in = sync_ff2;
`else
  assign sndrec_in = SNDREC;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sndrec_cur  <= 1'b0;
      sndrec_prev <= 1'b0;
    end else begin
      sndrec_cur  <= sndrec_in;
      sndrec_prev <= sndrec_cur;
    end
  end

  assign start     = sndrec_cur & ~sndrec_prev & (state == S_IDLE);
  assign setup_end = (cnt == SETUP_LAST);
  assign half_end  = (cnt == HALF_LAST);
  assign gap_end   = (cnt == GAP_LAST);
  assign bit_end   = phase & half_end;
  assign byte_end  = bit_end & (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == 3'd4);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start)     next_state = S_SETUP;
      S_SETUP: if (setup_end) next_state = S_XFER;
      S_XFER:  if (byte_end)  next_state = last_byte ? S_DONE : S_GAP;
      S_GAP:   if (gap_end)   next_state = S_XFER;
      S_DONE:                 next_state = S_IDLE;
      default:                next_state = S_IDLE;
    endcase
  end

  always_comb begin
    SS     = ~((state == S_SETUP) | (state == S_XFER) | (state == S_GAP));
    SCLK   = (state == S_XFER) & phase;
    BUSY   = (state != S_IDLE);
    DVALID = (state == S_DONE);
    MOSI   = mosi_r;
    DOUT   = dout_r;
  end

  // Phase counter, bit/byte counters, shifters; MOSI changes only at the start of a low phase.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt      <= '0;
      phase    <= 1'b0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 3'd0;
      cmd      <= 8'h00;
      rx_shift <= '0;
      mosi_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mosi_r <= 1'b0;
          if (start) begin
            cmd      <= DIN;
            cnt      <= '0;
            phase    <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
            rx_shift <= '0;
          end
        end
        S_SETUP: begin
          if (setup_end) begin
            cnt    <= '0;
            phase  <= 1'b0;
            mosi_r <= cmd[7];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_XFER: begin
          if (half_end) begin
            cnt   <= '0;
            phase <= ~phase;
            if (!phase) begin
              rx_shift <= {rx_shift[38:0], MISO};
            end else if (bit_cnt == 3'd7) begin
              bit_cnt  <= 3'd0;
              byte_cnt <= byte_cnt + 3'd1;
              mosi_r   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              mosi_r  <= (byte_cnt == 3'd0) ? cmd[3'd6 - bit_cnt] : 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (gap_end) begin
            cnt   <= '0;
            phase <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
          mosi_r <= 1'b0;
        end
        default: mosi_r <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      dout_r <= '0;
    else if ((state == S_XFER) && (next_state == S_DONE))
      dout_r <= rx_shift;
  end

endmodule

`default_nettype wire

// File: tb/tb_jstk_spi_ctrl.sv
// tb_jstk_spi_ctrl: directed bench for jstk_spi_ctrl with a mode-0 slave model and cycle-accurate timing checks.
`default_nettype none
`timescale 1ns/1ps

module tb_jstk_spi_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        SNDREC = 1'b0;
  logic [7:0]  DIN = 8'h84;
  logic        MISO;
  logic        SS, SCLK, MOSI, BUSY, DVALID;
  logic [39:0] DOUT;

  jstk_spi_ctrl dut (
    .CLK    (CLK),
    .RST    (RST),
    .SNDREC (SNDREC),
    .DIN    (DIN),
    .MISO   (MISO),
    .SS     (SS),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .BUSY   (BUSY),
    .DOUT   (DOUT),
    .DVALID (DVALID)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and slave model; slave shifts MISO after each SCLK fall.
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [39:0] mosi_cap = '0;
  logic [39:0] slave_data = '0;
  int rises = 0, falls = 0, ss_falls = 0, dvalid_cnt = 0;
  int ss_fall_cyc = 0, rise1_cyc = 0, rise2_cyc = 0, rise9_cyc = 0, fall8_cyc = 0, dvalid_cyc = 0;

  always @(negedge CLK) begin
    if (prev_ss && !SS) begin
      ss_fall_cyc = cyc;
      ss_falls++;
      rises = 0;
      falls = 0;
      mosi_cap = '0;
    end
    if (!prev_sclk && SCLK) begin
      rises++;
      mosi_cap = {mosi_cap[38:0], MOSI};
      if (rises == 1) rise1_cyc = cyc;
      if (rises == 2) rise2_cyc = cyc;
      if (rises == 9) rise9_cyc = cyc;
    end
    if (prev_sclk && !SCLK) begin
      falls++;
      if (falls == 8) fall8_cyc = cyc;
    end
    if (DVALID) begin
      dvalid_cnt++;
      dvalid_cyc = cyc;
    end
    MISO = (!SS && falls < 40) ? slave_data[39 - falls] : 1'b0;
    prev_ss = SS;
    prev_sclk = SCLK;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic wait_dvalid(input int prev_cnt, input int budget, input string tag);
    int n = 0;
    while (dvalid_cnt == prev_cnt && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(dvalid_cnt > prev_cnt), 64'd1);
  endtask

  initial begin
    int e, d0, s0, r0, n;

    // Reset
    RST = 1'b0;
    tick(5);
    check("rst_ss", 64'(SS), 64'd1);
    check("rst_sclk", 64'(SCLK), 64'd0);
    check("rst_mosi", 64'(MOSI), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_dvalid", 64'(DVALID), 64'd0);
    check("rst_dout", 64'(DOUT), 64'd0);
    RST = 1'b1;
    tick(3);

    // Basic transaction, DIN changed mid-flight, SNDREC held high afterwards
    slave_data = 40'h123456789A;
    SNDREC = 1'b1;
    e = cyc + 1;
    d0 = dvalid_cnt;
    s0 = ss_falls;
    tick(50);
    DIN = 8'h00;
    check("t1_busy_setup", 64'(BUSY), 64'd1);
    check("t1_ss_setup", 64'(SS), 64'd0);
    wait_dvalid(d0, 3000, "t1_dvalid_seen");
    check("t1_dvalid_cyc", 64'(dvalid_cyc), 64'(e + 1381));
    check("t1_ss_fall_cyc", 64'(ss_fall_cyc), 64'(e + 1));
    check("t1_dout", 64'(DOUT), 64'h123456789A);
    check("t1_rises", 64'(rises), 64'd40);
    check("t1_mosi", 64'(mosi_cap), 64'h8400000000);
    check("t1_sclk_period", 64'(rise2_cyc - rise1_cyc), 64'd12);
    check("t1_ss_to_rise", 64'(rise1_cyc - ss_fall_cyc), 64'd186);
    check("t1_gap_fall_rise", 64'(rise9_cyc - fall8_cyc), 64'd186);
    check("t1_busy_done", 64'(BUSY), 64'd1);
    check("t1_ss_done", 64'(SS), 64'd1);
    tick(1);
    check("t1_busy_after", 64'(BUSY), 64'd0);
    check("t1_dvalid_after", 64'(DVALID), 64'd0);
    tick(200);
    check("held_no_restart", 64'(ss_falls), 64'(s0 + 1));
    check("held_one_dvalid", 64'(dvalid_cnt), 64'(d0 + 1));

    // New rise with 0xFF slave bytes: DOUT holds until the new strobe
    DIN = 8'h84;
    SNDREC = 1'b0;
    tick(3);
    slave_data = 40'hFFFFFFFFFF;
    SNDREC = 1'b1;
    d0 = dvalid_cnt;
    tick(700);
    check("t2_dout_hold", 64'(DOUT), 64'h123456789A);
    wait_dvalid(d0, 3000, "t2_dvalid_seen");
    check("t2_dout", 64'(DOUT), 64'hFFFFFFFFFF);
    check("t2_mosi", 64'(mosi_cap), 64'h8400000000);

    // Re-trigger while busy
    SNDREC = 1'b0;
    tick(3);
    slave_data = 40'hA55AC33C0F;
    SNDREC = 1'b1;
    d0 = dvalid_cnt;
    s0 = ss_falls;
    tick(300);
    SNDREC = 1'b0;
    tick(3);
    SNDREC = 1'b1;
    tick(3);
    SNDREC = 1'b0;
    tick(3);
    SNDREC = 1'b1;
    wait_dvalid(d0, 3000, "t3_dvalid_seen");
    tick(300);
    check("t3_one_dvalid", 64'(dvalid_cnt), 64'(d0 + 1));
    check("t3_one_ss_fall", 64'(ss_falls), 64'(s0 + 1));
    check("t3_dout", 64'(DOUT), 64'hA55AC33C0F);

    // Reset during byte 2
    SNDREC = 1'b0;
    tick(3);
    slave_data = 40'h0102030405;
    SNDREC = 1'b1;
    n = 0;
    while (!(ss_falls > s0 + 1 && rises >= 20) && n < 2000) begin
      tick(1);
      n++;
    end
    check("t4_reached_byte2", 64'(rises), 64'd20);
    RST = 1'b0;
    #1;
    check("t4_async_ss", 64'(SS), 64'd1);
    check("t4_async_sclk", 64'(SCLK), 64'd0);
    check("t4_async_busy", 64'(BUSY), 64'd0);
    check("t4_async_mosi", 64'(MOSI), 64'd0);
    check("t4_async_dout", 64'(DOUT), 64'd0);
    tick(3);
    SNDREC = 1'b0;
    r0 = rises;
    s0 = ss_falls;
    d0 = dvalid_cnt;
    RST = 1'b1;
    tick(300);
    check("t4_no_sclk", 64'(rises), 64'(r0));
    check("t4_no_ss_fall", 64'(ss_falls), 64'(s0));
    check("t4_no_dvalid", 64'(dvalid_cnt), 64'(d0));
    check("t4_dout_zero", 64'(DOUT), 64'd0);
    check("t4_idle_busy", 64'(BUSY), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
